wb_bram_rmw_ctrl: RTL and testbench

WB_BRAM_RMW_CTRL -- requirements
Module: wb_bram_rmw_ctrl

---
 rtl/wb_bram_pkg.sv | 36 +++
 rtl/wb_bram_rmw_ctrl_addr_gen.sv | 30 +++
 rtl/wb_bram_rmw_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_wb_bram_rmw_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bram_pkg.sv
// Shared Wishbone cycle-type / burst-type codes and controller state encoding
// used by the BRAM read-modify-write controller.
package wb_bram_pkg;

   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'b000,
      CTI_CONST   = 3'b001,
      CTI_INCR    = 3'b010,
      CTI_EOB     = 3'b111
   } cti_e;

   typedef enum logic [1:0] {
      BTE_LINEAR       = 2'b00,
      BTE_FOUR_BEAT    = 2'b01,
      BTE_EIGHT_BEAT   = 2'b10,
      BTE_SIXTEEN_BEAT = 2'b11
   } bte_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_WR     = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4
   } state_e;

   function automatic logic cti_reserved(input logic [2:0] cti);
      return !(cti == CTI_CLASSIC || cti == CTI_CONST || cti == CTI_INCR || cti == CTI_EOB);
   endfunction

   // A beat carrying one of these codes keeps the burst open after it is acked.
   function automatic logic cti_continues(input logic [2:0] cti);
      return (cti == CTI_CONST) || (cti == CTI_INCR);
   endfunction

endpackage

// File: rtl/wb_bram_rmw_ctrl_addr_gen.sv
// Combinational next-beat address for Wishbone bursts: linear increment,
// 4/8/16-beat wrapping, or constant address.
module wb_burst_addr_gen
   import wb_bram_pkg::*;
#(
   parameter int Aw = 10
) (
   input  logic [Aw-1:0] addr_i,
   input  logic [1:0]    bte_i,
   input  logic [2:0]    cti_i,
   output logic [Aw-1:0] next_o
);

   logic [Aw-1:0] wrap_mask;

   always_comb begin
      case (bte_i)
         BTE_FOUR_BEAT:    wrap_mask = Aw'(3);
         BTE_EIGHT_BEAT:   wrap_mask = Aw'(7);
         BTE_SIXTEEN_BEAT: wrap_mask = Aw'(15);
         default:          wrap_mask = '1;
      endcase
      if (cti_i == CTI_CONST) begin
         next_o = addr_i;
      end else begin
         next_o = (addr_i & ~wrap_mask) | ((addr_i + Aw'(1)) & wrap_mask);
      end
   end

endmodule

// File: rtl/wb_bram_rmw_ctrl.sv
// Wishbone slave in front of a 1-cycle-latency BRAM; partial writes become a
// read-modify-write when the BRAM has no native byte enables.
//
// state     | meaning
// ST_IDLE   | waiting for a request; BRAM address follows sa_addr_i
// ST_RD     | read beats, ack with q while presenting the next address
// ST_WR     | full-word (or native byte-enable) write beats
// ST_RMW_RD | read phase of an RMW beat, no ack
// ST_RMW_WR | merge q with captured data/sel, write and ack
module wb_bram_rmw_ctrl
   import wb_bram_pkg::*;
#(
   parameter int Dw      = 32,
   parameter int Aw      = 10,
   parameter int SELw    = Dw / 8,
   parameter int CTIw    = 3,
   parameter int BTEw    = 2,
   parameter     BYTE_WE = "DISABLED"
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [Dw-1:0]   sa_dat_i,
   input  logic [SELw-1:0] sa_sel_i,
   input  logic [Aw-1:0]   sa_addr_i,
   input  logic [CTIw-1:0] sa_cti_i,
   input  logic [BTEw-1:0] sa_bte_i,
   input  logic            sa_stb_i,
   input  logic            sa_cyc_i,
   input  logic            sa_we_i,
   output logic [Dw-1:0]   sa_dat_o,
   output logic            sa_ack_o,
   output logic            sa_err_o,
   output logic            sa_rty_o,
   output logic [Dw-1:0]   d,
   output logic [Aw-1:0]   addr,
   output logic            we,
   output logic [SELw-1:0] be,
   input  logic [Dw-1:0]   q
);

   localparam bit NATIVE_BE = (BYTE_WE == "ENABLED");

   state_e          state_q, state_d;
   logic [Aw-1:0]   addr_q, addr_d;
   logic [Dw-1:0]   dat_q, dat_d;
   logic [SELw-1:0] sel_q, sel_d;
   logic            err_q, err_d;
   logic [Aw-1:0]   next_addr;
   logic [Dw-1:0]   merged;
   logic            direct_wr;
   logic            burst_more;

   wb_burst_addr_gen #(.Aw(Aw)) u_addr_gen (
      .addr_i (addr_q),
      .bte_i  (sa_bte_i[1:0]),
      .cti_i  (sa_cti_i[2:0]),
      .next_o (next_addr)
   );

   assign sa_dat_o   = q;
   assign sa_err_o   = err_q;
   assign sa_rty_o   = 1'b0;
   assign direct_wr  = NATIVE_BE || (&sa_sel_i);
   assign burst_more = cti_continues(sa_cti_i[2:0]);

   always_comb begin
      merged = q;
      for (int b = 0; b < SELw; b++) begin
         if (sel_q[b]) merged[8*b +: 8] = dat_q[8*b +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      dat_d    = dat_q;
      sel_d    = sel_q;
      err_d    = 1'b0;
      addr     = addr_q;
      d        = sa_dat_i;
      be       = sa_sel_i;
      we       = 1'b0;
      sa_ack_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            addr = sa_addr_i;
            if (sa_cyc_i && sa_stb_i && !err_q) begin
               addr_d = sa_addr_i;
               if (cti_reserved(sa_cti_i[2:0])) begin
                  err_d = 1'b1;
               end else if (!sa_we_i) begin
                  state_d = ST_RD;
               end else if (direct_wr) begin
                  state_d = ST_WR;
               end else begin
                  // The read for the merge is the address already presented here.
                  dat_d   = sa_dat_i;
                  sel_d   = sa_sel_i;
                  state_d = ST_RMW_WR;
               end
            end
         end
         ST_RD: begin
            if (!sa_cyc_i) begin
               state_d = ST_IDLE;
            end else if (sa_stb_i) begin
               sa_ack_o = 1'b1;
               if (burst_more) begin
                  addr   = next_addr;
                  addr_d = next_addr;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WR: begin
            if (!sa_cyc_i) begin
               state_d = ST_IDLE;
            end else if (sa_stb_i) begin
               if (direct_wr) begin
                  we       = 1'b1;
                  sa_ack_o = 1'b1;
                  if (burst_more) addr_d = next_addr;
                  else            state_d = ST_IDLE;
               end else begin
                  dat_d   = sa_dat_i;
                  sel_d   = sa_sel_i;
                  state_d = ST_RMW_WR;
               end
            end
         end
         ST_RMW_RD: begin
            if (!sa_cyc_i) begin
               state_d = ST_IDLE;
            end else if (sa_stb_i) begin
               dat_d   = sa_dat_i;
               sel_d   = sa_sel_i;
               state_d = ST_RMW_WR;
            end
         end
         ST_RMW_WR: begin
            if (!sa_cyc_i) begin
               state_d = ST_IDLE;
            end else if (sa_stb_i) begin
               we       = 1'b1;
               sa_ack_o = 1'b1;
               d        = merged;
               be       = '1;
               if (burst_more) begin
                  addr_d  = next_addr;
                  state_d = ST_RMW_RD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Reset suppresses a write that would otherwise land on the same edge.
      if (reset) begin
         we       = 1'b0;
         sa_ack_o = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_wb_bram_rmw_ctrl.sv
// Randomized Wishbone master plus a word-level shadow memory for the BRAM
// RMW controller, with directed cases pinning known addresses and data.
module tb_wb_bram_rmw_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] sa_dat_i, sa_dat_o, d, q;
   logic [3:0]  sa_sel_i, be;
   logic [9:0]  sa_addr_i, addr;
   logic [2:0]  sa_cti_i;
   logic [1:0]  sa_bte_i;
   logic        sa_stb_i, sa_cyc_i, sa_we_i;
   logic        sa_ack_o, sa_err_o, sa_rty_o, we;

   logic        ld_en;
   logic [9:0]  ld_addr;
   logic [31:0] ld_dat;

   logic [31:0] mem     [1024];
   logic [31:0] ref_mem [1024];

   logic [31:0] beat_dat   [16];
   logic [3:0]  beat_sel   [16];
   int          lat        [16];
   logic [9:0]  trace_addr [16];
   logic [31:0] rd_seen    [16];
   logic [31:0] wr_d_seen;
   logic [3:0]  wr_be_seen;
   logic        wr_beat_active = 1'b0;
   logic        chk_en = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_bram_rmw_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .sa_dat_i  (sa_dat_i),
      .sa_sel_i  (sa_sel_i),
      .sa_addr_i (sa_addr_i),
      .sa_cti_i  (sa_cti_i),
      .sa_bte_i  (sa_bte_i),
      .sa_stb_i  (sa_stb_i),
      .sa_cyc_i  (sa_cyc_i),
      .sa_we_i   (sa_we_i),
      .sa_dat_o  (sa_dat_o),
      .sa_ack_o  (sa_ack_o),
      .sa_err_o  (sa_err_o),
      .sa_rty_o  (sa_rty_o),
      .d         (d),
      .addr      (addr),
      .we        (we),
      .be        (be),
      .q         (q)
   );

   // Read-first BRAM with byte enables and a preload port.
   always @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_dat;
      end else if (we === 1'b1) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[addr][8*b +: 8] <= d[8*b +: 8];
      end
      q <= mem[addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Every BRAM write must coincide with an acked write beat, outside reset.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rty_low", 64'(sa_rty_o), 64'(0));
         if (we !== 1'b0)
            chk("we_only_on_write_ack", 64'({sa_ack_o, wr_beat_active, reset}), 64'(3'b110));
      end
   end

   function automatic logic [9:0] model_next(input logic [9:0] a, input logic [1:0] bte,
                                             input logic [2:0] mode);
      int size, base;
      if (mode == 3'b001) return a;
      size = (bte == 2'd0) ? 1024 : (2 << bte);
      base = int'(a) - (int'(a) % size);
      return 10'(base + ((int'(a) + 1) % size));
   endfunction

   task automatic load_word(input logic [9:0] a, input logic [31:0] v);
      ld_en = 1'b1; ld_addr = a; ld_dat = v;
      @(posedge clk); #1;
      ld_en = 1'b0;
      ref_mem[a] = v;
   endtask

   task automatic do_burst(input logic wr, input logic [9:0] start, input logic [1:0] bte,
                           input logic [2:0] mode, input int nbeats, input int gap_after,
                           input logic keep_cyc);
      logic [9:0]  a;
      logic [31:0] old, expw, eff;
      logic        partial;
      int          cnt, exp_lat;
      a = start;
      partial = 1'b0;
      for (int k = 0; k < nbeats; k++) if (beat_sel[k] != 4'hF) partial = wr;
      for (int k = 0; k < nbeats; k++) begin
         sa_cyc_i = 1'b1; sa_stb_i = 1'b1; sa_we_i = wr; sa_addr_i = a; sa_bte_i = bte;
         sa_cti_i = (mode == 3'b000) ? 3'b000 : ((k == nbeats - 1) ? 3'b111 : mode);
         sa_dat_i = beat_dat[k]; sa_sel_i = beat_sel[k];
         wr_beat_active = wr;
         trace_addr[k] = a;
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (sa_ack_o !== 1'b1 && cnt < 6);
         lat[k] = cnt;
         if (sa_ack_o !== 1'b1) begin
            chk("beat_ack_timeout", 64'(sa_ack_o), 64'(1));
            sa_cyc_i = 1'b0; sa_stb_i = 1'b0; wr_beat_active = 1'b0;
            @(posedge clk); #1;
            return;
         end
         exp_lat = (k == 0) ? 2 : (partial ? 2 : 1);
         chk($sformatf("beat_lat[%0d]", k), 64'(cnt), 64'(exp_lat));
         if (wr) begin
            old = ref_mem[a];
            for (int b = 0; b < 4; b++) begin
               expw[8*b +: 8] = beat_sel[k][b] ? beat_dat[k][8*b +: 8] : old[8*b +: 8];
               eff[8*b +: 8]  = (be[b] === 1'b1) ? d[8*b +: 8] : old[8*b +: 8];
            end
            chk("wr_addr_we", 64'({we, addr}), 64'({1'b1, a}));
            chk("wr_data", 64'(eff), 64'(expw));
            ref_mem[a] = expw;
            wr_d_seen = d; wr_be_seen = be;
         end else begin
            chk("rd_data", 64'(sa_dat_o), 64'(ref_mem[a]));
            rd_seen[k] = sa_dat_o;
         end
         @(posedge clk); #1;
         a = model_next(a, bte, mode);
         if (gap_after == k && k < nbeats - 1) begin
            sa_stb_i = 1'b0; wr_beat_active = 1'b0;
            @(negedge clk);
            chk("gap_quiet", 64'({sa_ack_o, we}), 64'(0));
            @(posedge clk); #1;
         end
      end
      sa_stb_i = 1'b0; sa_cyc_i = keep_cyc; sa_cti_i = 3'b000; wr_beat_active = 1'b0;
      @(negedge clk);
      chk("ack_drop", 64'({sa_ack_o, we}), 64'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  exp_tr [4];
      logic [31:0] exp_rd [4];
      logic        wr_r, part_r, keep_r;
      logic [2:0]  mode_r;
      int          nb, gap, bad;
      sa_dat_i = '0; sa_sel_i = '0; sa_addr_i = '0; sa_cti_i = '0; sa_bte_i = '0;
      sa_stb_i = 1'b0; sa_cyc_i = 1'b0; sa_we_i = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
      #1;
      for (int i = 0; i < 1024; i++) load_word(10'(i), $urandom);
      @(negedge clk);
      chk("reset_outputs", 64'({sa_ack_o, sa_err_o, we, sa_rty_o}), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("idle_outputs", 64'({sa_ack_o, sa_err_o, we}), 64'(0));
      @(posedge clk); #1;

      // Single read
      load_word(10'h005, 32'hDEADBEEF);
      beat_sel[0] = 4'hF; beat_dat[0] = '0;
      do_burst(1'b0, 10'h005, 2'd0, 3'b000, 1, -1, 1'b1);
      chk("single_rd_lit", 64'(rd_seen[0]), 64'(32'hDEADBEEF));
      chk("single_rd_lat", 64'(lat[0]), 64'(2));

      // Partial write through RMW, then read back
      load_word(10'h010, 32'h11223344);
      beat_sel[0] = 4'b0010; beat_dat[0] = 32'hAABBCCDD;
      do_burst(1'b1, 10'h010, 2'd0, 3'b000, 1, -1, 1'b1);
      chk("rmw_d_lit", 64'(wr_d_seen), 64'(32'h1122CC44));
      chk("rmw_be_lit", 64'(wr_be_seen), 64'(4'hF));
      chk("rmw_model_lit", 64'(ref_mem[10'h010]), 64'(32'h1122CC44));
      beat_sel[0] = 4'hF;
      do_burst(1'b0, 10'h010, 2'd0, 3'b000, 1, -1, 1'b0);
      chk("rmw_readback_lit", 64'(rd_seen[0]), 64'(32'h1122CC44));

      // 4-beat wrapping read
      load_word(10'h00C, 32'h0000C00C); load_word(10'h00D, 32'h0000D00D);
      load_word(10'h00E, 32'h0000E00E); load_word(10'h00F, 32'h0000F00F);
      exp_tr = '{10'h00E, 10'h00F, 10'h00C, 10'h00D};
      exp_rd = '{32'h0000E00E, 32'h0000F00F, 32'h0000C00C, 32'h0000D00D};
      for (int k = 0; k < 4; k++) beat_sel[k] = 4'hF;
      do_burst(1'b0, 10'h00E, 2'd1, 3'b010, 4, -1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("wrap_addr[%0d]", k), 64'(trace_addr[k]), 64'(exp_tr[k]));
         chk($sformatf("wrap_data[%0d]", k), 64'(rd_seen[k]), 64'(exp_rd[k]));
      end

      // Linear write burst across the top of the address space, stb gap after beat 1
      load_word(10'h002, 32'h02020202);
      beat_dat[0] = 32'hA1A1A1A1; beat_dat[1] = 32'hB2B2B2B2; beat_dat[2] = 32'hC3C3C3C3;
      for (int k = 0; k < 3; k++) beat_sel[k] = 4'hF;
      do_burst(1'b1, 10'h3FF, 2'd0, 3'b010, 3, 0, 1'b1);
      chk("lin_wr_3ff", 64'(mem[10'h3FF]), 64'(32'hA1A1A1A1));
      chk("lin_wr_000", 64'(mem[10'h000]), 64'(32'hB2B2B2B2));
      chk("lin_wr_001", 64'(mem[10'h001]), 64'(32'hC3C3C3C3));
      chk("lin_wr_002_untouched", 64'(mem[10'h002]), 64'(32'h02020202));

      // Reserved cycle type
      sa_cyc_i = 1'b1; sa_stb_i = 1'b1; sa_we_i = 1'b1; sa_cti_i = 3'b101;
      sa_addr_i = 10'h020; sa_dat_i = 32'h5A5A5A5A; sa_sel_i = 4'hF;
      @(negedge clk);
      chk("err_cycle_n", 64'({sa_ack_o, sa_err_o}), 64'(2'b00));
      @(negedge clk);
      chk("err_cycle_n1", 64'({sa_ack_o, sa_err_o}), 64'(2'b01));
      @(posedge clk); #1;
      sa_stb_i = 1'b0; sa_cyc_i = 1'b0; sa_cti_i = 3'b000;
      @(negedge clk);
      chk("err_cycle_n2", 64'(sa_err_o), 64'(0));
      @(posedge clk); #1;

      // Reset during beat 2 of a write burst
      sa_cyc_i = 1'b1; sa_stb_i = 1'b1; sa_we_i = 1'b1; sa_cti_i = 3'b010; sa_bte_i = 2'd0;
      sa_addr_i = 10'h100; sa_dat_i = 32'h13579BDF; sa_sel_i = 4'hF; wr_beat_active = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_beat1_ack", 64'(sa_ack_o), 64'(1));
      ref_mem[10'h100] = 32'h13579BDF;
      @(posedge clk); #1;
      sa_addr_i = 10'h101; sa_dat_i = 32'h2468ACE0; reset = 1'b1;
      @(negedge clk);
      chk("rst_beat2_no_we", 64'({sa_ack_o, we}), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_after_outputs", 64'({sa_ack_o, sa_err_o, we}), 64'(0));
      @(posedge clk); #1;
      sa_cyc_i = 1'b0; sa_stb_i = 1'b0; sa_cti_i = 3'b000; wr_beat_active = 1'b0;
      @(posedge clk); #1;
      chk("rst_beat2_mem", 64'(mem[10'h101]), 64'(ref_mem[10'h101]));

      // Randomized traffic
      for (int t = 0; t < 80; t++) begin
         wr_r   = 1'($urandom_range(0, 1));
         mode_r = 3'($urandom_range(0, 2));
         nb     = (mode_r == 3'b000) ? 1 : $urandom_range(1, 6);
         gap    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
         part_r = 1'($urandom_range(0, 1));
         keep_r = 1'($urandom_range(0, 1));
         for (int k = 0; k < nb; k++) begin
            beat_dat[k] = $urandom;
            beat_sel[k] = part_r ? 4'($urandom_range(1, 14)) : 4'hF;
         end
         do_burst(wr_r, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)), mode_r, nb, gap, keep_r);
      end
      sa_cyc_i = 1'b0;
      @(posedge clk); #1;

      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("mem_final_bad_words", 64'(bad), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
